// File: rtl/pmod_acl_sampler.sv
// ADXL362-class sampler: writes MEAS_CFG at init, then burst-reads AXES samples on fetch or periodic tick.
// Latency: (2+2*AXES) bytes of 2*N+1 cycles each, then DONE and the registered arrived pulse.
// Backpressure: one request can wait in pend; a further request while pend is set is dropped with overrun.
module pmod_acl_sampler #(
    parameter int         AXES     = 3,
    parameter int         DW       = 12,
    parameter int         PERIOD   = 100000,
    parameter logic [7:0] MEAS_CFG = 8'h22,
    parameter int         GAP      = 4,
    parameter int         ACCW     = 2*DW+2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 fetch,
    input  logic                 auto_en,
    input  logic [ACCW-1:0]      thresh,
    output logic                 ready,
    output logic                 arrived,
    output logic                 overrun,
    output logic [ACCW-1:0]      acc,
    output logic [AXES*DW-1:0]   sample,
    output logic                 alarm,
    output logic                 SCLK,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic                 CS
);
    typedef enum logic [3:0] {INIT0, INIT1, INIT2, GAPW, IDLE, RCMD, RADR, RDAT, DONE} state_t;

    localparam int         PW      = $clog2(PERIOD);
    localparam int         GW      = $clog2(GAP) + 1;
    localparam logic [2:0] BC_LAST = 3'(2*AXES-1);

    state_t                state, state_nxt;
    logic                  live, outst, pend, cs_q;
    logic [2:0]            bc;
    logic [GW-1:0]         gap_cnt;
    logic [PW-1:0]         per_cnt;
    logic                  spi_send, spi_ready, spi_arrived;
    logic [7:0]            spi_dati, spi_dato, lo_byte;
    logic                  byte_st, byte_done, tick, req, take;
    logic [15:0]           raw;
    logic signed [DW-1:0]  axis_val;
    logic signed [2*DW-1:0] axis_ext;
    logic [2*DW-1:0]       axis_sq;
    logic [ACCW-1:0]       acc_work;
    logic [AXES*DW-1:0]    shadow;

    SPI_Master #(.N(8)) u_spi (
        .clk     (Clock),
        .rst_n   (Reset),
        .send    (spi_send),
        .dataI   (spi_dati),
        .dataO   (spi_dato),
        .ready   (spi_ready),
        .arrived (spi_arrived),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    assign tick      = auto_en & (per_cnt == '0);
    assign req       = fetch | tick;
    assign byte_done = outst & spi_arrived;
    // live keeps spi_send low while reset is applied and for the first cycle after it
    assign spi_send  = live & byte_st & ~outst & spi_ready;
    assign ready     = (state == IDLE);
    assign CS        = cs_q;

    assign raw      = {spi_dato, lo_byte};
    assign axis_val = DW'(raw);
    assign axis_ext = (2*DW)'(axis_val);
    assign axis_sq  = axis_ext * axis_ext;

    always_comb begin
        state_nxt = state;
        byte_st   = 1'b0;
        spi_dati  = 8'h00;
        take      = 1'b0;
        case (state)
            INIT0: begin
                byte_st  = 1'b1;
                spi_dati = 8'h0A;
                if (byte_done) state_nxt = INIT1;
            end
            INIT1: begin
                byte_st  = 1'b1;
                spi_dati = 8'h2D;
                if (byte_done) state_nxt = INIT2;
            end
            INIT2: begin
                byte_st  = 1'b1;
                spi_dati = MEAS_CFG;
                if (byte_done) state_nxt = GAPW;
            end
            GAPW: begin
                if (gap_cnt == GW'(GAP-1)) state_nxt = IDLE;
            end
            IDLE: begin
                if (pend || req) begin
                    take      = 1'b1;
                    state_nxt = RCMD;
                end
            end
            RCMD: begin
                byte_st  = 1'b1;
                spi_dati = 8'h0B;
                if (byte_done) state_nxt = RADR;
            end
            RADR: begin
                byte_st  = 1'b1;
                spi_dati = 8'h0E;
                if (byte_done) state_nxt = RDAT;
            end
            RDAT: begin
                byte_st = 1'b1;
                if (byte_done && bc == BC_LAST) state_nxt = DONE;
            end
            DONE: state_nxt = GAPW;
            default: state_nxt = INIT0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= INIT0;
        else        state <= state_nxt;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            live     <= 1'b0;
            outst    <= 1'b0;
            pend     <= 1'b0;
            cs_q     <= 1'b1;
            bc       <= '0;
            gap_cnt  <= '0;
            per_cnt  <= PW'(PERIOD-1);
            lo_byte  <= '0;
            acc_work <= '0;
            shadow   <= '0;
            acc      <= '0;
            sample   <= '0;
            alarm    <= 1'b0;
            arrived  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            live    <= 1'b1;
            arrived <= (state == DONE);
            overrun <= req & pend & ~take;

            // a request in the same cycle as a pended start stays queued
            if (take)     pend <= pend & req;
            else if (req) pend <= 1'b1;

            if (!auto_en || per_cnt == '0) per_cnt <= PW'(PERIOD-1);
            else                           per_cnt <= per_cnt - PW'(1);

            if (spi_send)       outst <= 1'b1;
            else if (byte_done) outst <= 1'b0;

            if (spi_send && (state == INIT0 || state == RCMD)) cs_q <= 1'b0;
            if (state_nxt == GAPW && state != GAPW)            cs_q <= 1'b1;

            gap_cnt <= (state == GAPW) ? gap_cnt + GW'(1) : '0;

            if (state != RDAT)  bc <= '0;
            else if (byte_done) bc <= bc + 3'd1;

            if (state_nxt == RCMD && state != RCMD) acc_work <= '0;

            // sample bytes arrive little-endian: low byte first, then high byte completes the axis
            if (state == RDAT && byte_done) begin
                if (!bc[0]) begin
                    lo_byte <= spi_dato;
                end else begin
                    acc_work                  <= acc_work + ACCW'(axis_sq);
                    shadow[bc[2:1]*DW +: DW]  <= axis_val;
                end
            end

            if (state == DONE) begin
                acc    <= acc_work;
                sample <= shadow;
                alarm  <= (acc_work > thresh);
            end
        end
    end
endmodule

// SPI mode-0 byte engine, MSB first, SCLK = clk/2.
// Latency: 2*N cycles from the cycle after send to the arrived cycle; dataO is valid while arrived is high.
// Backpressure: ready is low while a byte is shifting; send is ignored then.
module SPI_Master #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         send,
    input  logic [N-1:0] dataI,
    output logic [N-1:0] dataO,
    output logic         ready,
    output logic         arrived,
    output logic         SCLK,
    output logic         MOSI,
    input  logic         MISO
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic          busy, sclk_q;
    logic [CW-1:0] cnt;
    logic [N-1:0]  tx_sh, rx_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            sclk_q <= 1'b0;
            cnt    <= '0;
            tx_sh  <= '0;
            rx_sh  <= '0;
        end else if (!busy) begin
            if (send) begin
                busy   <= 1'b1;
                sclk_q <= 1'b0;
                cnt    <= '0;
                tx_sh  <= dataI;
            end
        end else if (!sclk_q) begin
            sclk_q <= 1'b1;
            rx_sh  <= {rx_sh[N-2:0], MISO};
        end else begin
            sclk_q <= 1'b0;
            if (cnt == CW'(N-1)) begin
                busy <= 1'b0;
            end else begin
                cnt   <= cnt + CW'(1);
                tx_sh <= {tx_sh[N-2:0], 1'b0};
            end
        end
    end

    assign ready   = ~busy;
    assign arrived = busy & sclk_q & (cnt == CW'(N-1));
    assign dataO   = rx_sh;
    assign SCLK    = sclk_q;
    assign MOSI    = tx_sh[N-1];
endmodule

// File: tb/tb_pmod_acl_sampler.sv
// Directed bench: default build (AXES=3, DW=12, PERIOD=1000) plus a 1-axis 16-bit build, each with an SPI slave model.
module tb_pmod_acl_sampler;
    localparam int GAP      = 4;
    localparam int BYTE_CYC = 17;
    localparam int BURST    = (2+2*3)*BYTE_CYC + 1;

    logic        clk = 1'b0;
    logic        rst_n, fetch, auto_en;
    logic [25:0] thresh;
    logic        ready, arrived, overrun, alarm, sclk, mosi, miso, cs;
    logic [25:0] acc;
    logic [35:0] sample;

    logic        rst_v_n, fetch_v;
    logic [33:0] thresh_v;
    logic        ready_v, arrived_v, overrun_v, alarm_v, sclk_v, mosi_v, miso_v, cs_v;
    logic [33:0] acc_v;
    logic [15:0] sample_v;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pmod_acl_sampler #(.AXES(3), .DW(12), .PERIOD(1000), .MEAS_CFG(8'h22), .GAP(GAP)) u_dut (
        .Clock(clk), .Reset(rst_n), .fetch(fetch), .auto_en(auto_en), .thresh(thresh),
        .ready(ready), .arrived(arrived), .overrun(overrun), .acc(acc), .sample(sample),
        .alarm(alarm), .SCLK(sclk), .MOSI(mosi), .MISO(miso), .CS(cs)
    );

    pmod_acl_sampler #(.AXES(1), .DW(16), .PERIOD(1000), .MEAS_CFG(8'h22), .GAP(GAP)) u_var (
        .Clock(clk), .Reset(rst_v_n), .fetch(fetch_v), .auto_en(1'b0), .thresh(thresh_v),
        .ready(ready_v), .arrived(arrived_v), .overrun(overrun_v), .acc(acc_v), .sample(sample_v),
        .alarm(alarm_v), .SCLK(sclk_v), .MOSI(mosi_v), .MISO(miso_v), .CS(cs_v)
    );

    // SPI slave for the default build: logs MOSI bytes, returns resp_m after the two command bytes
    logic [7:0] resp_m [6];
    logic [7:0] cap_m [$];
    logic [7:0] sh_m = 8'h00;
    int bit_m = 0;
    int idx_m = 0;
    always @(negedge cs) begin
        bit_m = 0;
        idx_m = 0;
    end
    always @(posedge sclk) if (!cs) begin
        sh_m = {sh_m[6:0], mosi};
        bit_m++;
        if (bit_m == 8) begin
            cap_m.push_back(sh_m);
            bit_m = 0;
            idx_m++;
        end
    end
    assign miso = (!cs && idx_m >= 2 && idx_m < 8) ? resp_m[idx_m-2][7-bit_m] : 1'b0;

    logic [7:0] resp_v [2];
    logic [7:0] sh_v = 8'h00;
    int bit_v = 0;
    int idx_v = 0;
    always @(negedge cs_v) begin
        bit_v = 0;
        idx_v = 0;
    end
    always @(posedge sclk_v) if (!cs_v) begin
        sh_v = {sh_v[6:0], mosi_v};
        bit_v++;
        if (bit_v == 8) begin
            bit_v = 0;
            idx_v++;
        end
    end
    assign miso_v = (!cs_v && idx_v >= 2 && idx_v < 4) ? resp_v[idx_v-2][7-bit_v] : 1'b0;

    int   cyc = 0, arr_cnt = 0, arr_wide = 0, ovr_cnt = 0, ovr_wide = 0;
    int   t_arr = 0, t_cs_rise = 0, cs_falls = 0, arr_cnt_v = 0;
    logic arr_q = 1'b0, ovr_q = 1'b0, cs_prev = 1'b1;
    always @(negedge clk) begin
        cyc++;
        if (arrived) begin
            arr_cnt++;
            t_arr = cyc;
        end
        if (arrived && arr_q) arr_wide++;
        if (overrun) ovr_cnt++;
        if (overrun && ovr_q) ovr_wide++;
        if (cs && !cs_prev) t_cs_rise = cyc;
        if (!cs && cs_prev) cs_falls++;
        if (arrived_v) arr_cnt_v++;
        arr_q   = arrived;
        ovr_q   = overrun;
        cs_prev = cs;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_fetch();
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
    endtask

    task automatic wait_arr(input string tag, input int budget);
        int start = arr_cnt;
        int n = 0;
        while (arr_cnt == start && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 64'(arr_cnt - start), 64'd1);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            tick();
            n++;
        end
        chk(tag, ready, 1'b1);
    endtask

    initial begin
        int a0, o0, ta, n;
        int t_auto [5];
        rst_n = 1'b0; rst_v_n = 1'b0; fetch = 1'b0; fetch_v = 1'b0; auto_en = 1'b0;
        thresh = 26'd24; thresh_v = '0;
        resp_m = '{8'h03, 8'h00, 8'hFC, 8'h0F, 8'h00, 8'h00};
        resp_v = '{8'h00, 8'h80};
        repeat (3) tick();
        chk("rst_cs", cs, 1'b1);
        chk("rst_ready", ready, 1'b0);
        chk("rst_arrived", arrived, 1'b0);
        chk("rst_acc", acc, 0);
        chk("rst_sample", sample, 0);
        chk("rst_alarm", alarm, 1'b0);

        // init write: 0A 2D 22 in one CS window, ready GAP cycles after CS release
        rst_n = 1'b1; rst_v_n = 1'b1;
        wait_ready("init_ready", 200);
        chk("init_nbytes", cap_m.size(), 3);
        chk("init_b0", cap_m[0], 8'h0A);
        chk("init_b1", cap_m[1], 8'h2D);
        chk("init_b2", cap_m[2], 8'h22);
        chk("init_cs_windows", cs_falls, 1);
        chk("init_gap", 64'(cyc - t_cs_rise), GAP);

        cap_m.delete();
        pulse_fetch();
        chk("fetch_ready_drop", ready, 1'b0);
        wait_arr("b1", 400);
        chk("b1_sample", sample, 36'h000_FFC_003);
        chk("b1_acc", acc, 25);
        chk("b1_alarm", alarm, 1'b1);
        chk("b1_nbytes", cap_m.size(), 8);
        chk("b1_cmd", {cap_m[0], cap_m[1]}, 16'h0B0E);
        tick();
        chk("b1_arrived_1cyc", arrived, 1'b0);

        thresh = 26'd25;
        pulse_fetch();
        wait_arr("b2", 400);
        chk("b2_acc", acc, 25);
        chk("b2_alarm", alarm, 1'b0);

        // queueing: start, one pended, one dropped
        wait_ready("q_ready", 200);
        a0 = arr_cnt; o0 = ovr_cnt;
        pulse_fetch();
        repeat (20) tick();
        pulse_fetch();
        repeat (20) tick();
        pulse_fetch();
        repeat (2) tick();
        chk("q_overrun", 64'(ovr_cnt - o0), 1);
        wait_arr("qA", 400);
        ta = t_arr;
        wait_arr("qB", 400);
        chk("q_spacing", 64'(t_arr - ta), BURST + GAP + 1);
        repeat (400) tick();
        chk("q_total", 64'(arr_cnt - a0), 2);

        wait_ready("auto_ready", 200);
        auto_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_arr("auto", 1200);
            t_auto[i] = t_arr;
        end
        auto_en = 1'b0;
        for (int i = 1; i < 5; i++) chk("auto_period", 64'(t_auto[i] - t_auto[i-1]), 1000);
        a0 = arr_cnt;
        repeat (2500) tick();
        chk("auto_stop", 64'(arr_cnt - a0), 0);

        // reset during the third RDAT byte, then a fetch issued during re-init
        cap_m.delete();
        pulse_fetch();
        n = 0;
        while (cap_m.size() < 4 && n < 400) begin
            tick();
            n++;
        end
        chk("mid_reached", cap_m.size(), 4);
        repeat (5) tick();
        a0 = arr_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_cs", cs, 1'b1);
        chk("mid_acc", acc, 0);
        chk("mid_sample", sample, 0);
        chk("mid_arrived", arrived, 1'b0);
        tick();
        cap_m.delete();
        rst_n = 1'b1;
        repeat (3) tick();
        pulse_fetch();
        wait_arr("mid_pend", 600);
        chk("mid_reinit0", cap_m[0], 8'h0A);
        chk("mid_reinit1", cap_m[1], 8'h2D);
        chk("mid_reinit2", cap_m[2], 8'h22);
        chk("mid_rcmd", cap_m[3], 8'h0B);
        chk("mid_arrivals", 64'(arr_cnt - a0), 1);

        // 1-axis 16-bit build, most negative sample
        a0 = arr_cnt_v;
        n = 0;
        while (!ready_v && n < 200) begin
            tick();
            n++;
        end
        fetch_v = 1'b1;
        tick();
        fetch_v = 1'b0;
        n = 0;
        while (arr_cnt_v == a0 && n < 300) begin
            tick();
            n++;
        end
        chk("var_seen", 64'(arr_cnt_v - a0), 1);
        chk("var_sample", sample_v, 16'h8000);
        chk("var_acc", acc_v, 34'h0_4000_0000);

        chk("arrived_width", arr_wide, 0);
        chk("overrun_width", ovr_wide, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
